// File: rtl/data_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package data_mem_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DEPTH_DEF  = 512;

    typedef enum logic [1:0] {
        HDR0  = 2'd0,
        HDR1  = 2'd1,
        WORDS = 2'd2,
        RUN   = 2'd3
    } boot_state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_boot_loader.sv
// Boot loader: 16-bit LE word count header then LE words; write issued on the 4th byte of each word.
// Accepts one byte per cycle while loading, never stalls the stream; holds core in reset until RUN.
module mem_boot_loader
    import data_mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WA_W  = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            boot_skip_i,
    input  logic            ld_valid_i,
    input  logic [7:0]      ld_data_i,
    output logic            ld_ready_o,
    output logic            core_reset_o,
    output logic            load_err_o,
    output logic            run_o,
    output logic            wr_en_o,
    output logic [WA_W-1:0] wr_addr_o,
    output logic [31:0]     wr_dat_o
);

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    boot_state_t state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] buf_q, buf_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic        core_rst_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= HDR0;
            byte_cnt_q <= '0;
            buf_q      <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            buf_q      <= buf_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            core_rst_q <= (state_q == RUN);
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        buf_d      = buf_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        err_d      = err_q;
        ld_ready_o = 1'b0;
        wr_en_o    = 1'b0;
        wr_addr_o  = word_cnt_q[WA_W-1:0];
        wr_dat_o   = {ld_data_i, buf_q};
        case (state_q)
            HDR0: begin
                // Skip wins over a simultaneous byte, which is left unaccepted.
                if (boot_skip_i) begin
                    state_d = RUN;
                end else begin
                    ld_ready_o = 1'b1;
                    if (ld_valid_i) begin
                        len_d[7:0] = ld_data_i;
                        state_d    = HDR1;
                    end
                end
            end
            HDR1: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    len_d   = {ld_data_i, len_q[7:0]};
                    state_d = (len_d == 16'd0) ? RUN : WORDS;
                    if (len_d > DEPTH16) err_d = 1'b1;
                end
            end
            WORDS: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    buf_d      = {ld_data_i, buf_q[23:8]};
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_o    = (word_cnt_q < DEPTH16);
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_d == len_q) state_d = RUN;
                    end
                end
            end
            default: ;
        endcase
    end

    assign core_reset_o = core_rst_q;
    assign load_err_o   = err_q;
    assign run_o        = (state_q == RUN);

endmodule

// File: rtl/data_mem_responder.sv
// Unified SRAM with a read-only instruction port and a read/write data port; reads are read-first, 1 cycle.
// No backpressure on core ports; core stores are ignored until the boot loader reaches RUN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic [31:0]       instr_o,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_i,
    input  logic              wen0_i,
    input  logic [3:0]        wmask0_i,
    output logic [31:0]       data_o,
    input  logic              boot_skip_i,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    output logic              ld_ready_o,
    output logic              core_reset_o,
    output logic              load_err_o
);

    localparam int WA_W = ADDR_W - 2;

    logic [31:0]     mem [DEPTH];
    logic            run;
    logic            ld_wr_en;
    logic [WA_W-1:0] ld_wr_addr;
    logic [31:0]     ld_wr_dat;
    logic [1:0]      off;
    logic [7:0]      mask_wide;
    logic [3:0]      lane_mask;
    logic [31:0]     lane_dat;
    logic            core_we;
    logic [31:0]     instr_q;
    logic [31:0]     word_q;
    logic [1:0]      off_q;
    logic            unused_bits;

    mem_boot_loader #(.DEPTH(DEPTH), .WA_W(WA_W)) u_loader (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .boot_skip_i  (boot_skip_i),
        .ld_valid_i   (ld_valid_i),
        .ld_data_i    (ld_data_i),
        .ld_ready_o   (ld_ready_o),
        .core_reset_o (core_reset_o),
        .load_err_o   (load_err_o),
        .run_o        (run),
        .wr_en_o      (ld_wr_en),
        .wr_addr_o    (ld_wr_addr),
        .wr_dat_o     (ld_wr_dat)
    );

    // Store aligner: lanes pushed past byte 3 by a misaligned offset fall off the top.
    assign off       = data_addr_i[1:0];
    assign mask_wide = {4'b0000, wmask0_i} << off;
    assign lane_mask = mask_wide[3:0];
    assign lane_dat  = data_i << {off, 3'b000};
    assign core_we   = run & reset_i & ~wen0_i;

    always_ff @(posedge clk_i) begin
        if (ld_wr_en && reset_i) begin
            mem[ld_wr_addr] <= ld_wr_dat;
        end else if (core_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) mem[data_addr_i[ADDR_W-1:2]][8*b +: 8] <= lane_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            instr_q <= '0;
            word_q  <= '0;
            off_q   <= '0;
        end else begin
            instr_q <= mem[instr_addr_i[ADDR_W-1:2]];
            word_q  <= mem[data_addr_i[ADDR_W-1:2]];
            off_q   <= data_addr_i[1:0];
        end
    end

    assign instr_o     = instr_q;
    assign data_o      = word_q >> {off_q, 3'b000};
    assign unused_bits = &{1'b0, instr_addr_i[1:0]};

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte-stream-level reference model checked every cycle.
module tb_data_mem_responder;
    import data_mem_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [10:0] instr_addr_i, data_addr_i;
    logic [31:0] data_i;
    logic        wen0_i;
    logic [3:0]  wmask0_i;
    logic        boot_skip_i, ld_valid_i;
    logic [7:0]  ld_data_i;
    logic [31:0] instr_o, data_o;
    logic        ld_ready_o, core_reset_o, load_err_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    data_mem_responder dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .instr_addr_i (instr_addr_i),
        .instr_o      (instr_o),
        .data_addr_i  (data_addr_i),
        .data_i       (data_i),
        .wen0_i       (wen0_i),
        .wmask0_i     (wmask0_i),
        .data_o       (data_o),
        .boot_skip_i  (boot_skip_i),
        .ld_valid_i   (ld_valid_i),
        .ld_data_i    (ld_data_i),
        .ld_ready_o   (ld_ready_o),
        .core_reset_o (core_reset_o),
        .load_err_o   (load_err_o)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference model: loader progress tracked purely as a count of accepted stream bytes.
    logic [31:0] m_mem   [512];
    logic [3:0]  m_known [512];
    logic [7:0]  m_buf   [4];
    int          m_n;
    logic [15:0] m_len;
    logic        m_run, m_err, m_core_rst;
    logic [31:0] e_instr, e_data;
    logic        e_instr_ok, e_data_ok;
    logic        model_live = 1'b0;

    always @(posedge clk_i) begin
        int wi, wd, o, k;
        wi = int'(instr_addr_i[10:2]);
        wd = int'(data_addr_i[10:2]);
        o  = int'(data_addr_i[1:0]);
        if (!reset_i) begin
            model_live = 1'b1;
            m_n = 0; m_len = '0; m_run = 1'b0; m_err = 1'b0; m_core_rst = 1'b0;
            e_instr = '0; e_data = '0; e_instr_ok = 1'b1; e_data_ok = 1'b1;
        end else begin
            e_instr    = m_mem[wi];
            e_instr_ok = (m_known[wi] == 4'hF);
            e_data     = m_mem[wd] >> (8 * o);
            e_data_ok  = (m_known[wd] == 4'hF);
            m_core_rst = m_run;
            if (m_run) begin
                if (!wen0_i) begin
                    for (int b = 0; b < 4; b++) begin
                        if (b >= o && wmask0_i[b-o]) begin
                            m_mem[wd][8*b +: 8] = data_i[8*(b-o) +: 8];
                            m_known[wd][b]      = 1'b1;
                        end
                    end
                end
            end else if (m_n == 0 && boot_skip_i) begin
                m_run = 1'b1;
            end else if (ld_valid_i) begin
                if (m_n == 0) m_len[7:0] = ld_data_i;
                else if (m_n == 1) m_len[15:8] = ld_data_i;
                else begin
                    m_buf[(m_n-2) % 4] = ld_data_i;
                    k = (m_n - 2) / 4;
                    if ((m_n - 2) % 4 == 3 && k < 512) begin
                        m_mem[k]   = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                        m_known[k] = 4'hF;
                    end
                end
                m_n++;
                if (m_n == 2 && m_len > 16'd512) m_err = 1'b1;
                if (m_n >= 2 && (m_len == 16'd0 || m_n == 2 + 4 * int'(m_len))) m_run = 1'b1;
            end
        end
    end

    always @(negedge clk_i) begin
        if (model_live) begin
            chk("ld_ready_o", {31'b0, ld_ready_o}, {31'b0, !m_run && !(m_n == 0 && boot_skip_i)});
            chk("core_reset_o", {31'b0, core_reset_o}, {31'b0, m_core_rst});
            chk("load_err_o", {31'b0, load_err_o}, {31'b0, m_err});
            if (e_instr_ok) chk("instr_o", instr_o, e_instr);
            if (e_data_ok) chk("data_o", data_o, e_data);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        ld_valid_i = 1'b1;
        ld_data_i  = b;
        cyc();
        ld_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        cyc();
        cyc();
        reset_i = 1'b1;
    endtask

    task automatic store(input logic [10:0] a, input logic [31:0] d, input logic [3:0] m);
        data_addr_i = a; data_i = d; wmask0_i = m; wen0_i = 1'b0;
        cyc();
        wen0_i = 1'b1;
    endtask

    task automatic rd(input logic [10:0] a);
        data_addr_i = a;
        cyc();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " instr_o"}, instr_o, 32'h0);
        chk({tag, " data_o"}, data_o, 32'h0);
        chk({tag, " ld_ready_o"}, {31'b0, ld_ready_o}, 32'h1);
        chk({tag, " core_reset_o"}, {31'b0, core_reset_o}, 32'h0);
        chk({tag, " load_err_o"}, {31'b0, load_err_o}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            m_known[i] = 4'h0;
            m_mem[i]   = '0;
        end
        reset_i = 1'b0; instr_addr_i = '0; data_addr_i = '0; data_i = '0;
        wen0_i = 1'b1; wmask0_i = MASK_W; boot_skip_i = 1'b0;
        ld_valid_i = 1'b0; ld_data_i = '0;
        #2;
        do_reset();
        chk_reset_outs("reset");

        // Two-word load
        send(8'h02); send(8'h00);
        send_word(32'h0000_0013);
        send_word(32'h0000_12B7);
        chk("load core_reset_o at last byte", {31'b0, core_reset_o}, 32'h0);
        chk("load ld_ready_o after", {31'b0, ld_ready_o}, 32'h0);
        cyc();
        chk("load core_reset_o +1", {31'b0, core_reset_o}, 32'h1);
        instr_addr_i = 11'h004;
        rd(11'h000);
        chk("mem[0] via data_o", data_o, 32'h0000_0013);
        chk("mem[1] via instr_o", instr_o, 32'h0000_12B7);
        rd(11'h004);
        chk("mem[1] via data_o", data_o, 32'h0000_12B7);

        // Byte store into lane 2, then read back at the same offset
        store(11'h010, 32'hAABB_CCDD, MASK_W);
        store(11'h012, 32'h0000_0011, MASK_B);
        rd(11'h012);
        chk("byte load [7:0]", {24'b0, data_o[7:0]}, 32'h11);
        chk("byte load off2", data_o, 32'h0000_AA11);
        rd(11'h010);
        chk("mem[4] after byte store", data_o, 32'hAA11_CCDD);

        // Half load at offset 2
        store(11'h014, 32'h8000_1234, MASK_W);
        rd(11'h016);
        chk("half load off2", {16'b0, data_o[15:0]}, 32'h8000);

        // Misaligned word store keeps only lane 3
        store(11'h003, 32'h5566_7788, MASK_W);
        rd(11'h000);
        chk("misaligned word store", data_o, 32'h8800_0013);

        // Read-first on word 8 from both ports
        store(11'h020, 32'h0102_0304, MASK_W);
        instr_addr_i = 11'h020;
        store(11'h020, 32'hDEAD_BEEF, MASK_W);
        chk("read-first data_o", data_o, 32'h0102_0304);
        chk("read-first instr_o", instr_o, 32'h0102_0304);
        cyc();
        chk("after write data_o", data_o, 32'hDEAD_BEEF);
        chk("after write instr_o", instr_o, 32'hDEAD_BEEF);

        // Reset in the middle of word 1 of a 3-word load
        do_reset();
        send(8'h03); send(8'h00);
        send_word(32'hCAFE_F00D);
        send(8'h11); send(8'h22);
        reset_i = 1'b0;
        cyc();
        chk_reset_outs("mid-load reset");
        reset_i = 1'b1;
        instr_addr_i = 11'h004;
        rd(11'h000);
        chk("mem[0] retained", data_o, 32'hCAFE_F00D);
        chk("mem[1] untouched", instr_o, 32'h0000_12B7);
        send(8'h01); send(8'h00);
        send_word(32'h1122_3344);
        cyc();
        chk("restart core_reset_o", {31'b0, core_reset_o}, 32'h1);
        rd(11'h000);
        chk("restart mem[0]", data_o, 32'h1122_3344);

        // Zero-length header
        do_reset();
        send(8'h00); send(8'h00);
        chk("zero-len core_reset_o early", {31'b0, core_reset_o}, 32'h0);
        chk("zero-len ld_ready_o", {31'b0, ld_ready_o}, 32'h0);
        cyc();
        chk("zero-len core_reset_o", {31'b0, core_reset_o}, 32'h1);

        // Boot skip with a simultaneous byte
        do_reset();
        boot_skip_i = 1'b1; ld_valid_i = 1'b1; ld_data_i = 8'h05;
        #1;
        chk("skip ld_ready_o", {31'b0, ld_ready_o}, 32'h0);
        cyc();
        boot_skip_i = 1'b0; ld_valid_i = 1'b0;
        chk("skip ld_ready_o in RUN", {31'b0, ld_ready_o}, 32'h0);
        cyc();
        chk("skip core_reset_o", {31'b0, core_reset_o}, 32'h1);
        rd(11'h000);
        chk("skip mem[0] unchanged", data_o, 32'h1122_3344);

        // Oversized header: 513 words, last one dropped
        do_reset();
        send(8'h01); send(8'h02);
        chk("oversize load_err_o", {31'b0, load_err_o}, 32'h1);
        for (int k = 0; k < 513; k++) send_word(32'h5A00_0000 | k);
        chk("oversize ld_ready_o end", {31'b0, ld_ready_o}, 32'h0);
        cyc();
        chk("oversize core_reset_o", {31'b0, core_reset_o}, 32'h1);
        rd(11'h000);
        chk("oversize mem[0]", data_o, 32'h5A00_0000);
        rd(11'h7FC);
        chk("oversize mem[511]", data_o, 32'h5A00_01FF);
        chk("oversize err sticky", {31'b0, load_err_o}, 32'h1);
        do_reset();
        chk("err cleared by reset", {31'b0, load_err_o}, 32'h0);

        cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
